// File: rtl/chargen_fifo.sv
// Character generator feeding a DEPTH-entry show-ahead FIFO; chip-select-gated
// read strobes pop codes onto a registered output port.
module chargen_fifo #(
  parameter int unsigned       WIDTH    = 8,
  parameter logic [WIDTH-1:0]  INITCHAR = "a",
  parameter logic [WIDTH-1:0]  LASTCHAR = "z",
  parameter int unsigned       STEP     = 1,
  parameter int unsigned       DEPTH    = 4,
  parameter bit                WRAP     = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             n_cs,
  input  logic             n_rd,
  input  logic             n_clr,
  output logic [WIDTH-1:0] port,
  output logic             n_empty,
  output logic             n_full,
  output logic             done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [WIDTH:0] STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] LAST_X  = {1'b0, LASTCHAR};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_ptr_p1;
  logic [CW-1:0]    count, count_nx;
  logic [WIDTH-1:0] gen, gen_nx, port_nx;
  logic [WIDTH:0]   gen_sum;
  logic             done_nx, at_end;
  logic             pop, push;

  // Handshake: a pop is a selected read strobe against a non-empty FIFO; the
  // generator is the producer and pushes whenever a slot is free this cycle
  // (including the slot a same-cycle pop releases) until it reports done.
  always_comb begin
    pop       = !n_cs && !n_rd && (count != '0);
    push      = !done && ((count != DEPTH_C) || pop);
    rd_ptr_p1 = rd_ptr + AW'(1);
    gen_sum   = {1'b0, gen} + STEP_X;
    at_end    = gen_sum > LAST_X;

    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase

    gen_nx  = gen;
    done_nx = done;
    if (push) begin
      if (!at_end)   gen_nx  = gen_sum[WIDTH-1:0];
      else if (WRAP) gen_nx  = INITCHAR;
      else           done_nx = 1'b1;
    end

    // Next head: when the popped entry was the only one, the head is the code
    // being pushed this cycle; an empty FIFO keeps the last value shown.
    port_nx = port;
    if (count_nx != '0) begin
      if (pop)                port_nx = (count > CW'(1)) ? mem[rd_ptr_p1] : gen;
      else if (count == '0)   port_nx = gen;
    end
  end

  always_ff @(posedge clk) begin
    if (n_clr && push) mem[wr_ptr] <= gen;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      gen     <= INITCHAR;
      done    <= 1'b0;
      port    <= INITCHAR;
      n_empty <= 1'b0;
      n_full  <= 1'b1;
    end else if (!n_clr) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      gen     <= INITCHAR;
      done    <= 1'b0;
      port    <= INITCHAR;
      n_empty <= 1'b0;
      n_full  <= 1'b1;
    end else begin
      count   <= count_nx;
      if (pop)  rd_ptr <= rd_ptr_p1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      gen     <= gen_nx;
      done    <= done_nx;
      port    <= port_nx;
      n_empty <= (count_nx != '0);
      n_full  <= (count_nx != DEPTH_C);
    end
  end

endmodule

// File: doc/chargen_fifo.md
Name: chargen_fifo

Overview:
Parametrised successor of the single-register character generator. An internal generator walks a configurable character range and pushes codes into a DEPTH-entry show-ahead FIFO. Chip-select-gated read strobes pop codes onto `port`. It sits on the same 8-bit peripheral bus, with bus-style active-low strobes and status flags, and can either stop at the last character or wrap around.

Parameters:
- WIDTH, 8, data width of `port` and the generator.
- INITCHAR, "a", first code generated; also the reset value of `port`.
- LASTCHAR, "z", final code of the range; INITCHAR <= LASTCHAR is required.
- STEP, 1, increment between successive codes; must be >= 1.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- WRAP, 0, 0 = stop after LASTCHAR, 1 = continue from INITCHAR after LASTCHAR.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- n_cs  in  1  active-low chip select; gates `n_rd`.
- n_rd  in  1  active-low read strobe; pops one entry per clock.
- n_clr  in  1  synchronous active-low restart.
- port  out  WIDTH  oldest unread code (show-ahead).
- n_empty  out  1  active-low, 0 = FIFO empty.
- n_full  out  1  active-low, 0 = FIFO full.
- done  out  1  1 = generator finished (WRAP=0 only).

Behaviour:
- Reset is asynchronous and active-low: while n_rst=0, outputs are forced immediately, with no clock edge needed:
  - port = INITCHAR, n_empty = 0, n_full = 1, done = 0.
  - Count = 0, generator = INITCHAR, pointers = 0.
- pop = (n_cs==0 && n_rd==0 && count>0). A read strobe on an empty FIFO is ignored; no underflow and no pointer movement.
- push = (done==0 && (count<DEPTH || pop)). When full, a simultaneous pop frees the slot, so push and pop occur together in the same cycle.
- count update per clock: count += push - pop. Simultaneous push and pop leaves count unchanged.
- Generator advance on push:
  - If gen == LASTCHAR or gen+STEP > LASTCHAR (compare in WIDTH+1 bits, no overflow):
    - WRAP=1: gen <= INITCHAR.
    - WRAP=0: done <= 1 and gen holds.
  - Else gen <= gen + STEP.
- Once done=1, no further pushes occur; it clears only on reset or n_clr.
- port timing:
  - port is registered and equals the FIFO head whenever n_empty=1.
  - After a pop it shows the next entry at the same clock edge.
  - If the FIFO becomes empty, port holds the last popped value.
  - Writing into an empty FIFO updates port at that edge; latency from push to port is 1 clock.
- First clock after reset release pushes INITCHAR: port stays INITCHAR and n_empty goes 1 at that edge.
- n_empty and n_full are registered, derived from the next count, and change at the same edge as count.
- n_clr=0 at a clock edge: FIFO flushed (count 0, pointers 0), gen = INITCHAR, done = 0, port = INITCHAR, n_empty = 0, n_full = 1. n_clr overrides any push and pop in that cycle.
- Pointers wrap modulo DEPTH.
- All outputs are glitch-free registers; there is no combinational path from inputs to outputs.

Test Plan:
- Reset check (bench: WIDTH 8, DEPTH 4, LASTCHAR "c", WRAP 0). Pulse n_rst low for one cycle, then release.
  - Required: port='a', n_empty=0, n_full=1, done=0 during reset.
  - Required: n_empty=1 and port='a' one clock after release.
- Stop mode (WRAP 0, LASTCHAR "c"), no reads for 5 clocks.
  - Required: done=1 after 3 pushes, n_full=1 (count 3 < 4).
  - Then hold n_cs=0, n_rd=0 for 3 clocks: port steps a→b→c, n_empty=0 after third pop, port holds 'c', done stays 1.
- Wrap mode (WRAP 1, LASTCHAR "c"), idle 4 clocks.
  - Required: n_full=0, FIFO holds a,b,c,a.
  - Then read continuously for 6 clocks: port sequence a,b,c,a,b,c and n_full remains 0 throughout (simultaneous push/pop).
- Select gating: with FIFO non-empty, n_rd=0 and n_cs=1 for 3 clocks.
  - Required: port unchanged, count unchanged.
- Restart: after popping 'a' and 'b', drive n_clr=0 for one clock.
  - Required: port='a', n_empty=0, done=0 at that edge.
  - Required: next clock n_empty=1 with port='a'.
- Mid-operation reset: assert n_rst at T0 offset between edges while full and reading.
  - Required: port='a', n_empty=0, n_full=1 immediately, before the next clock edge.
- Odd-step boundary: STEP 2, INITCHAR "a", LASTCHAR "d", WRAP 0.
  - Required: generated codes are a, c only, then done=1 with no overflow past 'd'.
